// File: rtl/light_sequencer.sv
// Traffic-lamp sequencer: GREEN/YELLOW/RED/DARK rounds with alarm override.
// Optional macro CHEAT_FREEZE_EN: cheat_out freezes the timed phases.
module light_sequencer #(
   parameter int GREEN_T    = 35,
   parameter int YELLOW_T   = 6,
   parameter int RED_T      = 12,
   parameter int DARK_T     = 13,
   parameter int NUM_ROUNDS = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       a3,
   input  logic       cheat_out,
   output logic       green,
   output logic       yellow,
   output logic       red,
   output logic [2:0] phase,
   output logic [5:0] remaining,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GREEN  = 3'd1,
      YELLOW = 3'd2,
      RED    = 3'd3,
      DARK   = 3'd4,
      ALARM  = 3'd5
   } phase_t;

   localparam logic [5:0] GREEN_LOAD  = 6'(GREEN_T - 1);
   localparam logic [5:0] YELLOW_LOAD = 6'(YELLOW_T - 1);
   localparam logic [5:0] RED_LOAD    = 6'(RED_T - 1);
   localparam logic [5:0] DARK_LOAD   = 6'(DARK_T - 1);
   localparam logic [3:0] ROUNDS_L    = 4'(NUM_ROUNDS);

   phase_t      phase_r, next_phase_s;
   logic [5:0]  rem_r, next_rem_s;
   logic [3:0]  round_r, next_round_s, round_inc_s;
   logic        done_r, next_done_s;
   logic        green_r, yellow_r, red_r;
   logic        freeze_s;

`ifdef CHEAT_FREEZE_EN
   assign freeze_s = cheat_out;
`else
   logic cheat_unused_s;
   assign cheat_unused_s = cheat_out;
   assign freeze_s       = 1'b0;
`endif

   assign round_inc_s = round_r + 4'd1;

   // Next-state selection; alarm beats freeze, freeze beats countdown/expiry.
   always_comb begin
      next_phase_s = phase_r;
      next_rem_s   = rem_r;
      next_round_s = round_r;
      next_done_s  = 1'b0;
      case (phase_r)
         IDLE: begin
            if (start) begin
               next_phase_s = GREEN;
               next_rem_s   = GREEN_LOAD;
               next_round_s = 4'd0;
            end else begin
               next_rem_s   = 6'd0;
            end
         end
         GREEN, YELLOW, RED, DARK: begin
            if (a3) begin
               next_phase_s = ALARM;
               next_rem_s   = 6'd0;
            end else if (freeze_s) begin
               next_rem_s   = rem_r;
            end else if (rem_r != 6'd0) begin
               next_rem_s   = rem_r - 6'd1;
            end else begin
               case (phase_r)
                  GREEN: begin
                     next_phase_s = YELLOW;
                     next_rem_s   = YELLOW_LOAD;
                  end
                  YELLOW: begin
                     next_phase_s = RED;
                     next_rem_s   = RED_LOAD;
                  end
                  RED: begin
                     next_phase_s = DARK;
                     next_rem_s   = DARK_LOAD;
                  end
                  DARK: begin
                     next_round_s = round_inc_s;
                     if (round_inc_s == ROUNDS_L) begin
                        next_phase_s = IDLE;
                        next_rem_s   = 6'd0;
                        next_done_s  = 1'b1;
                     end else begin
                        next_phase_s = GREEN;
                        next_rem_s   = GREEN_LOAD;
                     end
                  end
                  default: begin
                     next_phase_s = IDLE;
                     next_rem_s   = 6'd0;
                  end
               endcase
            end
         end
         ALARM: begin
            if (a3) begin
               next_rem_s   = 6'd0;
            end else begin
               next_phase_s = RED;
               next_rem_s   = RED_LOAD;
            end
         end
         default: begin
            next_phase_s = IDLE;
            next_rem_s   = 6'd0;
            next_round_s = 4'd0;
         end
      endcase
   end

   // State and lamp registers; lamps decode the next phase so they align with it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_r  <= IDLE;
         rem_r    <= 6'd0;
         round_r  <= 4'd0;
         done_r   <= 1'b0;
         green_r  <= 1'b0;
         yellow_r <= 1'b0;
         red_r    <= 1'b0;
      end else begin
         phase_r  <= next_phase_s;
         rem_r    <= next_rem_s;
         round_r  <= next_round_s;
         done_r   <= next_done_s;
         green_r  <= (next_phase_s == GREEN);
         yellow_r <= (next_phase_s == YELLOW);
         red_r    <= (next_phase_s == RED) || (next_phase_s == ALARM);
      end
   end

   assign phase     = phase_r;
   assign remaining = rem_r;
   assign done      = done_r;
   assign green     = green_r;
   assign yellow    = yellow_r;
   assign red       = red_r;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: round-position reference model, random and targeted stimulus.
module tb_light_sequencer;

   localparam int G   = 35;
   localparam int Y   = 6;
   localparam int R   = 12;
   localparam int D   = 13;
   localparam int N   = 2;
   localparam int TOT = G + Y + R + D;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       a3 = 1'b0;
   logic       cheat_out = 1'b0;
   logic       green, yellow, red, done;
   logic [2:0] phase;
   logic [5:0] remaining;

   light_sequencer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .a3        (a3),
      .cheat_out (cheat_out),
      .green     (green),
      .yellow    (yellow),
      .red       (red),
      .phase     (phase),
      .remaining (remaining),
      .done      (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] ph;
      logic [5:0] rem;
      logic       g, y, r, d;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: position within a round plus run/alarm flags.
   bit m_run = 0, m_alarm = 0, m_done = 0;
   int m_t = 0, m_rounds = 0;

   function automatic void model_view(output int ph, output int rem);
      if (m_alarm) begin ph = 5; rem = 0; end
      else if (!m_run) begin ph = 0; rem = 0; end
      else if (m_t < G) begin ph = 1; rem = G - 1 - m_t; end
      else if (m_t < G + Y) begin ph = 2; rem = G + Y - 1 - m_t; end
      else if (m_t < G + Y + R) begin ph = 3; rem = G + Y + R - 1 - m_t; end
      else begin ph = 4; rem = TOT - 1 - m_t; end
   endfunction

   function automatic exp_t model_exp();
      exp_t e;
      int ph, rem;
      model_view(ph, rem);
      e.ph  = 3'(ph);
      e.rem = 6'(rem);
      e.g   = (ph == 1);
      e.y   = (ph == 2);
      e.r   = (ph == 3) || (ph == 5);
      e.d   = m_done;
      return e;
   endfunction

   function automatic void model_step();
      bit freeze;
`ifdef CHEAT_FREEZE_EN
      freeze = cheat_out;
`else
      freeze = 1'b0;
`endif
      m_done = 0;
      if (!reset_n) begin
         m_run = 0; m_alarm = 0; m_t = 0; m_rounds = 0;
      end else if (m_alarm) begin
         if (!a3) begin m_alarm = 0; m_t = G + Y; end
      end else if (!m_run) begin
         if (start) begin m_run = 1; m_t = 0; m_rounds = 0; end
      end else if (a3) begin
         m_alarm = 1;
      end else if (!freeze) begin
         m_t++;
         if (m_t == TOT) begin
            m_t = 0;
            m_rounds++;
            if (m_rounds == N) begin m_run = 0; m_done = 1; end
         end
      end
   endfunction

   task automatic check(string tag, exp_t e);
      n_vec++;
      if (phase !== e.ph || remaining !== e.rem || green !== e.g || yellow !== e.y ||
          red !== e.r || done !== e.d) begin
         n_err++;
         $display("FAIL %s t=%0t: got phase=%0d rem=%0d gyr=%b%b%b done=%b, want phase=%0d rem=%0d gyr=%b%b%b done=%b",
                  tag, $time, phase, remaining, green, yellow, red, done,
                  e.ph, e.rem, e.g, e.y, e.r, e.d);
      end
   endtask

   // Monitor: one expected entry is produced per rising edge, consumed on the falling edge.
   initial begin
      @(posedge clock);
      forever begin
         @(negedge clock);
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty t=%0t: no expected entry", $time);
         end else begin
            check("cycle", sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      model_step();
      sb.push_back(model_exp());
      #2;
   endtask

   task automatic do_reset();
      exp_t z;
      z = '{ph: 3'd0, rem: 6'd0, g: 1'b0, y: 1'b0, r: 1'b0, d: 1'b0};
      reset_n = 1'b0;
      start   = 1'b1;
      m_run = 0; m_alarm = 0; m_t = 0; m_rounds = 0; m_done = 0;
      sb.delete();
      sb.push_back(z);
      #1;
      check("async_reset", z);
      tick();
      reset_n = 1'b1;
      start   = 1'b0;
   endtask

   task automatic wait_model(int want_ph, int want_rem, int limit);
      int ph, rem;
      for (int i = 0; i < limit; i++) begin
         model_view(ph, rem);
         if (ph == want_ph && (want_rem < 0 || rem == want_rem)) begin
            start = 1'b0;
            return;
         end
         start = (ph == 0);
         tick();
      end
      n_vec++;
      n_err++;
      $display("FAIL wait_timeout: phase %0d rem %0d not reached within %0d cycles", want_ph, want_rem, limit);
      start = 1'b0;
   endtask

   initial begin
      int ph, rem, burst;
      burst = 0;
      tick();
      tick();
      reset_n = 1'b1;
      repeat (3) tick();

      // Full two-round run, with stray start pulses during DARK.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (140) begin
         model_view(ph, rem);
         start = (ph == 4) && ($urandom_range(0, 3) == 0) && (rem > 1 || m_rounds == 0);
         tick();
      end
      start = 1'b0;

      // Alarm raised in GREEN at remaining 10 for five cycles.
      wait_model(1, 10, 200);
      a3 = 1'b1;
      repeat (5) tick();
      a3 = 1'b0;
      repeat (20) tick();

      // Alarm rising exactly as YELLOW expires.
      wait_model(2, 0, 300);
      a3 = 1'b1;
      tick();
      a3 = 1'b0;
      repeat (15) tick();

      // Cheat indication for eight cycles in GREEN at remaining 20.
      wait_model(1, 20, 300);
      cheat_out = 1'b1;
      repeat (8) tick();
      cheat_out = 1'b0;
      repeat (5) tick();

      // Reset pulse in the middle of RED.
      wait_model(3, 5, 300);
      do_reset();
      repeat (3) tick();

      // Randomized traffic.
      repeat (3000) begin
         start     = ($urandom_range(0, 9) == 0);
         cheat_out = ($urandom_range(0, 4) == 0);
         if (burst > 0) begin
            a3 = 1'b1;
            burst--;
         end else if ($urandom_range(0, 49) == 0) begin
            a3 = 1'b1;
            burst = $urandom_range(0, 5);
         end else begin
            a3 = 1'b0;
         end
         if ($urandom_range(0, 599) == 0) do_reset();
         else tick();
      end

      start = 1'b0;
      a3 = 1'b0;
      cheat_out = 1'b0;
      @(negedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
